// File: rtl/alu_ctrl_pipe.sv
// Registered ALU function decoder with NZCV flag register and condition gating.
// Optional commit/squash counters are enabled by defining ALU_CTRL_PIPE_STATS_EN.
module alu_ctrl_pipe #(
  parameter int         FUNCT_W     = 6,
  parameter int         ALUCTRL_W   = 2,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ALUOp,
  input  logic [FUNCT_W-1:0]   Funct,
  input  logic [3:0]           Cond,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [3:0]           ALUFlags,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           FlagW,
  output logic                 NoWrite,
  output logic                 RegWEn,
  output logic                 CondEx,
  output logic                 IllegalOp,
  output logic [3:0]           Flags
`ifdef ALU_CTRL_PIPE_STATS_EN
  ,
  output logic [15:0]          CommitCount,
  output logic [15:0]          SquashCount
`endif
);

  logic [3:0]           cmd;
  logic                 s_bit;
  logic                 unused_funct;
  logic [ALUCTRL_W-1:0] dec_ctrl;
  logic [1:0]           dec_fw;
  logic                 dec_nw;
  logic                 dec_ill;
  logic [1:0]           fw_raw;
  logic [3:0]           cond_q;
  logic                 cond_pass;
  logic                 load;
  logic                 accept;

  assign cmd          = Funct[4:1];
  assign s_bit        = Funct[0];
  assign unused_funct = ^(Funct >> 5);

  always_comb begin
    dec_ctrl = '0;
    dec_fw   = 2'b00;
    dec_nw   = 1'b0;
    dec_ill  = 1'b0;
    if (ALUOp) begin
      unique case (1'b1)
        cmd == 4'b0100: begin
          dec_fw = {2{s_bit}};
        end
        cmd == 4'b0010: begin
          dec_ctrl = ALUCTRL_W'(2'b01);
          dec_fw   = {2{s_bit}};
        end
        cmd == 4'b0000: begin
          dec_ctrl = ALUCTRL_W'(2'b10);
          dec_fw   = {s_bit, 1'b0};
        end
        cmd == 4'b1100: begin
          dec_ctrl = ALUCTRL_W'(2'b11);
          dec_fw   = {s_bit, 1'b0};
        end
        cmd == 4'b1010: begin
          dec_ctrl = ALUCTRL_W'(2'b01);
          dec_fw   = 2'b11;
          dec_nw   = 1'b1;
        end
        cmd == 4'b1000: begin
          dec_ctrl = ALUCTRL_W'(2'b10);
          dec_fw   = 2'b10;
          dec_nw   = 1'b1;
        end
        default: begin
          dec_nw  = 1'b1;
          dec_ill = 1'b1;
        end
      endcase
    end
  end

  // Flags = {N,Z,C,V}
  always_comb begin
    cond_pass = 1'b0;
    case (cond_q)
      4'h0: cond_pass = Flags[2];
      4'h1: cond_pass = ~Flags[2];
      4'h2: cond_pass = Flags[1];
      4'h3: cond_pass = ~Flags[1];
      4'h4: cond_pass = Flags[3];
      4'h5: cond_pass = ~Flags[3];
      4'h6: cond_pass = Flags[0];
      4'h7: cond_pass = ~Flags[0];
      4'h8: cond_pass = Flags[1] & ~Flags[2];
      4'h9: cond_pass = ~Flags[1] | Flags[2];
      4'hA: cond_pass = Flags[3] == Flags[0];
      4'hB: cond_pass = Flags[3] != Flags[0];
      4'hC: cond_pass = ~Flags[2] & (Flags[3] == Flags[0]);
      4'hD: cond_pass = Flags[2] | (Flags[3] != Flags[0]);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign CondEx   = out_valid & cond_pass;
  assign FlagW    = fw_raw & {2{CondEx}};
  assign RegWEn   = ~NoWrite & CondEx & ~IllegalOp;
  assign in_ready = ~out_valid | out_ready;
  assign load     = in_valid & in_ready;
  assign accept   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      ALUControl <= '0;
      fw_raw     <= 2'b00;
      NoWrite    <= 1'b0;
      IllegalOp  <= 1'b0;
      cond_q     <= 4'h0;
      Flags      <= RESET_FLAGS;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        ALUControl <= dec_ctrl;
        fw_raw     <= dec_fw;
        NoWrite    <= dec_nw;
        IllegalOp  <= dec_ill;
        cond_q     <= Cond;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (accept && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef ALU_CTRL_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CommitCount <= 16'h0;
      SquashCount <= 16'h0;
    end else if (accept) begin
      if (CondEx && CommitCount != 16'hFFFF)
        CommitCount <= CommitCount + 16'h1;
      if (!CondEx && SquashCount != 16'hFFFF)
        SquashCount <= SquashCount + 16'h1;
    end
  end
`endif

endmodule
